// File: rtl/control_sequencer_if.sv
// Control sequencer <-> datapath bundle: IR contents and memory handshake in,
// register-transfer strobes out.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, MARin, IncPC;
  logic        memRead, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  alu_op;
  logic        run;
  logic        illegal;

  modport master (
    input  ir, mem_ready,
    output PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin,
           Rin, Rout, alu_op, run, illegal
  );

  modport slave (
    output ir, mem_ready,
    input  PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin,
           Rin, Rout, alu_op, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired control unit: fetch T0-T2, execute T3-T6, one step per clock.
// Decodes reg-reg ALU ops, MUL, NOP and HALT from the instruction register.
module control_sequencer #(
  parameter bit MUL_EN = 1'b1
) (
  input logic                  clock,
  input logic                  clear,
  control_sequencer_if.master  bus
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_mul, is_nop, is_halt;
  logic       unused_ir_bits;

  assign opcode         = bus.ir[31:27];
  assign ra             = bus.ir[26:23];
  assign rb             = bus.ir[22:19];
  assign rc             = bus.ir[18:15];
  assign unused_ir_bits = ^bus.ir[14:0];

  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_mul  = MUL_EN && (opcode == OP_MUL);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);

  // Step sequencing: fetch, memory stall in T1, then opcode-dependent execute.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (bus.mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_alu || is_mul) state_d = S_T4;
        else if (is_halt)     state_d = S_HALT;
        else                  state_d = S_T0;  // NOP and illegal opcodes
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_mul ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // State register with synchronous clear overriding every state, HALT included.
  always_ff @(posedge clock) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Strobes decode from the current step and the live IR; IR loads on the
  // same edge that enters T3, so T3 strobes cannot be precomputed a cycle early.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.memRead  = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.Rin      = '0;
    bus.Rout     = '0;
    bus.alu_op   = '0;
    bus.run      = 1'b1;
    bus.illegal  = 1'b0;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
      end
      S_T1: begin
        bus.memRead = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_mul) begin
          bus.Rout = 16'h0001 << rb;
          bus.Yin  = 1'b1;
        end else if (!is_nop && !is_halt) begin
          bus.illegal = 1'b1;
        end
      end
      S_T4: begin
        bus.Rout   = 16'h0001 << rc;
        bus.Zin    = 1'b1;
        bus.alu_op = opcode;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_mul) bus.LOin = 1'b1;
        else        bus.Rin  = 16'h0001 << ra;
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: bus.run = 1'b0;  // RST and HALT
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: per-cycle expected strobe vectors are
// queued as stimulus is driven and compared when the cycle's outputs settle.
module tb_control_sequencer;

  typedef struct packed {
    logic        PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;
  } out_t;

  typedef struct {
    logic        mr;
    logic        clr;
    logic [31:0] irv;
    out_t        exp;
  } step_t;

  localparam logic [31:0] GARB  = 32'h0123_4567;
  localparam logic [31:0] I_AND = 32'h5091_8000;
  localparam logic [31:0] I_ADD = 32'h1A2B_0000;
  localparam logic [31:0] I_MUL = 32'h7811_8000;
  localparam logic [31:0] I_NOP = 32'hD000_0000;
  localparam logic [31:0] I_HLT = 32'hD800_0000;
  localparam logic [31:0] I_ILL = 32'hF800_0000;

  logic        clk;
  logic        clr;
  logic        mr_v;
  logic [31:0] ir_v;
  int          n_checks;
  int          n_fail;
  out_t        exp_q[$];
  out_t        got1, got2;

  control_sequencer_if b1 ();
  control_sequencer_if b2 ();

  assign b1.ir        = ir_v;
  assign b1.mem_ready = mr_v;
  assign b2.ir        = ir_v;
  assign b2.mem_ready = mr_v;

  control_sequencer #(.MUL_EN(1'b1)) dut (.clock(clk), .clear(clr), .bus(b1.master));
  control_sequencer #(.MUL_EN(1'b0)) dut_nomul (.clock(clk), .clear(clr), .bus(b2.master));

  assign got1 = {b1.PCout, b1.MARin, b1.IncPC, b1.memRead, b1.MDRin, b1.MDRout, b1.IRin,
                 b1.Yin, b1.Zin, b1.Zlowout, b1.Zhighout, b1.LOin, b1.HIin,
                 b1.Rin, b1.Rout, b1.alu_op, b1.run, b1.illegal};
  assign got2 = {b2.PCout, b2.MARin, b2.IncPC, b2.memRead, b2.MDRin, b2.MDRout, b2.IRin,
                 b2.Yin, b2.Zin, b2.Zlowout, b2.Zhighout, b2.LOin, b2.HIin,
                 b2.Rin, b2.Rout, b2.alu_op, b2.run, b2.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobe patterns, one per step kind.
  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t o_t0();
    out_t o = '0;
    o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_t1();
    out_t o = '0;
    o.memRead = 1'b1; o.MDRin = 1'b1; o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_t2();
    out_t o = '0;
    o.MDRout = 1'b1; o.IRin = 1'b1; o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_t3(logic [15:0] rout);
    out_t o = '0;
    o.Rout = rout; o.Yin = 1'b1; o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_t4(logic [15:0] rout, logic [4:0] op);
    out_t o = '0;
    o.Rout = rout; o.Zin = 1'b1; o.alu_op = op; o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_t5(logic [15:0] rin, logic lo);
    out_t o = '0;
    o.Zlowout = 1'b1; o.Rin = rin; o.LOin = lo; o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_t6();
    out_t o = '0;
    o.Zhighout = 1'b1; o.HIin = 1'b1; o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_none();
    out_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction
  function automatic out_t o_ill();
    out_t o = '0;
    o.run = 1'b1; o.illegal = 1'b1;
    return o;
  endfunction

  function automatic step_t S(logic mr, logic [31:0] irv, out_t e, logic c = 1'b0);
    step_t s;
    s.mr = mr; s.clr = c; s.irv = irv; s.exp = e;
    return s;
  endfunction

  // Leaves the DUTs in RST with clear already released.
  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    step_t plan[$];
    out_t  want;
    clr = 1'b1; @(posedge clk); #1;
    plan.push_back(S(1'b1, GARB, o_idle(), 1'b1));
    plan.push_back(S(1'b1, GARB, o_idle(), 1'b1));
    plan.push_back(S(1'b0, GARB, o_idle()));
    plan.push_back(S(1'b0, GARB, o_t0()));
    plan.push_back(S(1'b0, GARB, o_t1()));
    foreach (plan[i]) begin
      mr_v = plan[i].mr; clr = plan[i].clr; ir_v = plan[i].irv;
      exp_q.push_back(plan[i].exp);
      @(negedge clk);
      want = exp_q.pop_front(); n_checks++;
      if (got1 !== want) begin
        n_fail++; $display("FAIL reset step %0d: got %h expected %h", i, got1, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_and();
    step_t plan[$];
    out_t  want;
    do_clear();
    plan.push_back(S(1'b0, GARB,  o_idle()));
    plan.push_back(S(1'b1, GARB,  o_t0()));   // mem_ready outside T1 ignored
    plan.push_back(S(1'b1, GARB,  o_t1()));
    plan.push_back(S(1'b1, GARB,  o_t2()));
    plan.push_back(S(1'b1, I_AND, o_t3(16'h0004)));
    plan.push_back(S(1'b0, I_AND, o_t4(16'h0008, 5'b01010)));
    plan.push_back(S(1'b0, I_AND, o_t5(16'h0002, 1'b0)));
    plan.push_back(S(1'b0, I_AND, o_t0()));
    foreach (plan[i]) begin
      mr_v = plan[i].mr; clr = plan[i].clr; ir_v = plan[i].irv;
      exp_q.push_back(plan[i].exp);
      @(negedge clk);
      want = exp_q.pop_front(); n_checks++;
      if (got1 !== want) begin
        n_fail++; $display("FAIL and step %0d: got %h expected %h", i, got1, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    step_t plan[$];
    out_t  want;
    do_clear();
    plan.push_back(S(1'b0, GARB,  o_idle()));
    plan.push_back(S(1'b0, GARB,  o_t0()));
    plan.push_back(S(1'b0, GARB,  o_t1()));
    plan.push_back(S(1'b0, GARB,  o_t1()));
    plan.push_back(S(1'b0, GARB,  o_t1()));
    plan.push_back(S(1'b1, GARB,  o_t1()));
    plan.push_back(S(1'b0, GARB,  o_t2()));
    plan.push_back(S(1'b0, I_ADD, o_t3(16'h0020)));
    plan.push_back(S(1'b0, I_ADD, o_t4(16'h0040, 5'b00011)));
    plan.push_back(S(1'b0, I_ADD, o_t5(16'h0010, 1'b0)));
    plan.push_back(S(1'b0, I_ADD, o_t0()));
    foreach (plan[i]) begin
      mr_v = plan[i].mr; clr = plan[i].clr; ir_v = plan[i].irv;
      exp_q.push_back(plan[i].exp);
      @(negedge clk);
      want = exp_q.pop_front(); n_checks++;
      if (got1 !== want) begin
        n_fail++; $display("FAIL stall step %0d: got %h expected %h", i, got1, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul(input bit use2);
    step_t plan[$];
    out_t  want, got;
    do_clear();
    plan.push_back(S(1'b0, GARB,  o_idle()));
    plan.push_back(S(1'b0, GARB,  o_t0()));
    plan.push_back(S(1'b1, GARB,  o_t1()));
    plan.push_back(S(1'b0, GARB,  o_t2()));
    if (use2) begin
      plan.push_back(S(1'b0, I_MUL, o_ill()));
      plan.push_back(S(1'b0, I_MUL, o_t0()));
    end else begin
      plan.push_back(S(1'b0, I_MUL, o_t3(16'h0004)));
      plan.push_back(S(1'b0, I_MUL, o_t4(16'h0008, 5'b01111)));
      plan.push_back(S(1'b0, I_MUL, o_t5(16'h0000, 1'b1)));
      plan.push_back(S(1'b0, I_MUL, o_t6()));
      plan.push_back(S(1'b0, I_MUL, o_t0()));
    end
    foreach (plan[i]) begin
      mr_v = plan[i].mr; clr = plan[i].clr; ir_v = plan[i].irv;
      exp_q.push_back(plan[i].exp);
      @(negedge clk);
      got  = use2 ? got2 : got1;
      want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mul(mul_en=%0d) step %0d: got %h expected %h", !use2, i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nop_illegal(input logic [31:0] instr, input out_t t3_exp, input string nm);
    step_t plan[$];
    out_t  want;
    do_clear();
    plan.push_back(S(1'b0, GARB,  o_idle()));
    plan.push_back(S(1'b0, GARB,  o_t0()));
    plan.push_back(S(1'b1, GARB,  o_t1()));
    plan.push_back(S(1'b0, GARB,  o_t2()));
    plan.push_back(S(1'b0, instr, t3_exp));
    plan.push_back(S(1'b0, instr, o_t0()));
    plan.push_back(S(1'b1, instr, o_t1()));
    foreach (plan[i]) begin
      mr_v = plan[i].mr; clr = plan[i].clr; ir_v = plan[i].irv;
      exp_q.push_back(plan[i].exp);
      @(negedge clk);
      want = exp_q.pop_front(); n_checks++;
      if (got1 !== want) begin
        n_fail++; $display("FAIL %s step %0d: got %h expected %h", nm, i, got1, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    step_t plan[$];
    out_t  want;
    do_clear();
    plan.push_back(S(1'b0, GARB,  o_idle()));
    plan.push_back(S(1'b0, GARB,  o_t0()));
    plan.push_back(S(1'b1, GARB,  o_t1()));
    plan.push_back(S(1'b0, GARB,  o_t2()));
    plan.push_back(S(1'b0, I_HLT, o_none()));
    for (int k = 0; k < 10; k++) plan.push_back(S(1'b1, I_ADD, o_idle()));
    plan.push_back(S(1'b0, I_ADD, o_idle(), 1'b1));
    plan.push_back(S(1'b0, I_ADD, o_idle()));
    plan.push_back(S(1'b0, I_ADD, o_t0()));
    foreach (plan[i]) begin
      mr_v = plan[i].mr; clr = plan[i].clr; ir_v = plan[i].irv;
      exp_q.push_back(plan[i].exp);
      @(negedge clk);
      want = exp_q.pop_front(); n_checks++;
      if (got1 !== want) begin
        n_fail++; $display("FAIL halt step %0d: got %h expected %h", i, got1, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    step_t plan[$];
    out_t  want;
    do_clear();
    plan.push_back(S(1'b0, GARB,  o_idle()));
    plan.push_back(S(1'b0, GARB,  o_t0()));
    plan.push_back(S(1'b1, GARB,  o_t1()));
    plan.push_back(S(1'b0, GARB,  o_t2()));
    plan.push_back(S(1'b0, I_AND, o_t3(16'h0004)));
    plan.push_back(S(1'b0, I_AND, o_t4(16'h0008, 5'b01010), 1'b1));
    plan.push_back(S(1'b0, I_AND, o_idle()));
    plan.push_back(S(1'b0, I_AND, o_t0()));
    foreach (plan[i]) begin
      mr_v = plan[i].mr; clr = plan[i].clr; ir_v = plan[i].irv;
      exp_q.push_back(plan[i].exp);
      @(negedge clk);
      want = exp_q.pop_front(); n_checks++;
      if (got1 !== want) begin
        n_fail++; $display("FAIL reset_midop step %0d: got %h expected %h", i, got1, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b1;
    mr_v     = 1'b0;
    ir_v     = GARB;
    test_reset();
    test_and();
    test_stall();
    test_mul(1'b0);
    test_mul(1'b1);
    test_nop_illegal(I_NOP, o_none(), "nop");
    test_nop_illegal(I_ILL, o_ill(), "illegal");
    test_halt();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hard-wired control unit that sits directly upstream of the CPU datapath. It generates, one clock per step, the register-transfer control strobes that the datapath expects: fetch (T0–T2), then execute (T3–T6). It decodes the instruction register for register-to-register ALU ops, MUL, NOP and HALT. Memory read completion is handshaked through `mem_ready`.

## Interface
Parameters:
- `MUL_EN`, default 1: when 0, the MUL opcode is decoded as illegal.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `ir`  in  32  IR register output. Fields: opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
- `mem_ready`  in  1  memory read data valid this cycle.
- `PCout`, `MARin`, `IncPC`  out  1 each  fetch strobes.
- `memRead`, `MDRin`, `MDRout`, `IRin`  out  1 each  memory/IR strobes.
- `Yin`, `Zin`, `Zlowout`, `Zhighout`, `LOin`, `HIin`  out  1 each  ALU path strobes.
- `Rin`  out  16  one-hot register write enables (bit n drives RnIn).
- `Rout`  out  16  one-hot register bus drives (bit n drives RnOut).
- `alu_op`  out  5  ALU operation; equals `ir[31:27]` in T4, else 0.
- `run`  out  1  high unless halted or in reset.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: ADD=00011, SUB=00100, AND=01010, OR=01011, MUL=01111, NOP=11010, HALT=11011. All others are illegal.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are Moore-decoded from the state (and `ir` in T3–T6) and are held for the full cycle. Any strobe not listed for a state is 0.
- RST: all outputs 0, `run`=0. Next state is T0.
- T0: `PCout`, `MARin`, `IncPC`. Next state is T1.
- T1: `memRead`, `MDRin`. Stay in T1 while `mem_ready`=0; go to T2 when `mem_ready`=1. Strobes stay asserted throughout the stall.
- T2: `MDRout`, `IRin`. Next state is T3. `ir` is valid from T3 onward.
- T3:
  - ALU ops and MUL: `Rout[rb]`, `Yin`; next state T4.
  - NOP: no strobes; next state T0.
  - HALT: no strobes; next state HALT.
  - Illegal: `illegal`=1; next state T0.
- T4: `Rout[rc]`, `Zin`, `alu_op`=opcode. Next state is T5.
- T5:
  - ALU ops: `Zlowout`, `Rin[ra]`; next state T0.
  - MUL: `Zlowout`, `LOin`; next state T6. The `ra` field is ignored.
- T6 (MUL only): `Zhighout`, `HIin`. Next state is T0.
- HALT: `run`=0, no strobes. Stays in HALT until `clear`.
- `Rin` and `Rout` are always zero or one-hot; never more than one bit set. R0 is written like any other register.

## Timing
- `clear` sampled high at a rising edge puts the state in RST on that edge, from any state, including a T1 stall or HALT. All outputs are 0 the following cycle.
- First fetch: T0 is the first cycle after `clear` deasserts, plus one RST cycle.
- Latency with zero-wait memory (`mem_ready` high on the first T1 cycle):
  - ALU op: 6 cycles, T0→T5.
  - MUL: 7 cycles.
  - NOP or illegal: 4 cycles.
- Each extra T1 cycle with `mem_ready`=0 adds one cycle.
- `mem_ready` is ignored outside T1.
- `illegal` is high for exactly one cycle (T3), with no register strobes that cycle.
- `run`=1 in T0 through T6 and during stalls; 0 in RST and HALT.

## Test plan
- AND: after clear, feed `ir`=0x5091_8000 (AND R1,R2,R3) with `mem_ready` high in T1 → strobe sequence:
  - T0: PCout/MARin/IncPC.
  - T1: memRead/MDRin.
  - T2: MDRout/IRin.
  - T3: `Rout`=0x0004, Yin.
  - T4: `Rout`=0x0008, Zin, `alu_op`=01010.
  - T5: Zlowout, `Rin`=0x0002.
  - Then T0 again.
- Stall: ADD R4,R5,R6 (`ir`=0x1A2B_0000) with `mem_ready` low for 3 T1 cycles → memRead/MDRin held 4 cycles. Then T3 `Rout`=0x0020, T4 `Rout`=0x0040, T5 `Rin`=0x0010. Total 9 cycles.
- MUL: `ir`=0x7811_8000 → T5 Zlowout+LOin, T6 Zhighout+HIin, `Rin`=0 throughout. With `MUL_EN`=0: `illegal` pulses in T3, then T0.
- HALT/NOP: `ir`=0xD000_0000 → T3 then T0, no strobes. `ir`=0xD800_0000 → HALT, `run`=0 held for 10 cycles; `clear` → RST → T0.
- Illegal: `ir`=0xF800_0000 → `illegal`=1 for one cycle, `Rin`/`Rout`=0, then T0.
- Reset mid-op: assert `clear` during T4 → next cycle all outputs 0 and state RST, then T0 with `run`=1.
